// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding SRAM-like bus between the
// instruction-fetch port and the data-access port, and generates the fetch
// and data stall signals for the hazard unit.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              i_stall,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              d_stall,

    input  logic              longest_stall,
    input  logic              flush_except,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    state_t state;
    owner_t owner;
    logic   instDone;
    logic   dataDone;
    logic   discard;

    logic   finishNow;
    logic   keepResult;

    // Transaction completion this cycle, and whether its result is still wanted.
    // A flush in the completing cycle already makes the result stale.
    always_comb begin
        finishNow = 1'b0;
        case (state)
            ADDR:    finishNow = bus_addr_ok & bus_data_ok;
            WAIT:    finishNow = bus_data_ok;
            default: finishNow = 1'b0;
        endcase
        keepResult = finishNow & ~discard & ~flush_except;
    end

    // Stalls come only from registered done flags and the live requests.
    assign i_stall = inst_req & ~instDone;
    assign d_stall = data_req & ~dataDone;

    // Bus FSM: arbitration in IDLE (data first), request phase, data wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            discard   <= 1'b0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= 2'd0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (data_req && !dataDone) begin
                        bus_req   <= 1'b1;
                        bus_wr    <= data_wr;
                        bus_size  <= data_size;
                        bus_addr  <= data_addr;
                        bus_wdata <= data_wdata;
                        owner     <= OWN_DATA;
                        state     <= ADDR;
                    end else if (inst_req && !instDone) begin
                        bus_req   <= 1'b1;
                        bus_wr    <= 1'b0;
                        bus_size  <= SIZE_WORD;
                        bus_addr  <= inst_addr;
                        owner     <= OWN_INST;
                        state     <= ADDR;
                    end
                end
                ADDR, WAIT: begin
                    if (finishNow) begin
                        state   <= IDLE;
                        owner   <= OWN_NONE;
                        bus_req <= 1'b0;
                        discard <= 1'b0;
                    end else begin
                        if (state == ADDR && bus_addr_ok) begin
                            state   <= WAIT;
                            bus_req <= 1'b0;
                        end
                        if (flush_except) begin
                            discard <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    owner   <= OWN_NONE;
                    bus_req <= 1'b0;
                    discard <= 1'b0;
                end
            endcase
        end
    end

    // Result holding: cleared when the pipeline advances or flushes; a new
    // result landing in the same cycle takes precedence over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instDone   <= 1'b0;
            dataDone   <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            if (!longest_stall || flush_except) begin
                instDone <= 1'b0;
                dataDone <= 1'b0;
            end
            if (keepResult) begin
                if (owner == OWN_INST) begin
                    instDone   <= 1'b1;
                    inst_rdata <= bus_rdata;
                end
                if (owner == OWN_DATA) begin
                    dataDone <= 1'b1;
                    if (!bus_wr) begin
                        data_rdata <= bus_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, reset corner case, then random
// traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        flush_except;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .i_stall(i_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .d_stall(d_stall),
        .longest_stall(longest_stall), .flush_except(flush_except),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the expectations the table pins down.
    typedef struct {
        logic        iReq;
        logic [31:0] iAddr;
        logic        dReq;
        logic        dWr;
        logic [1:0]  dSize;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic        aOk;
        logic        dOk;
        logic [31:0] rdata;
        logic        lst;
        logic        fl;
        logic        eI;
        logic        eD;
        logic        eReq;
        logic        eWr;
        logic [1:0]  eSize;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
        logic [31:0] eIR;
        logic [31:0] eDR;
    } vec_t;

    int nVec  = 0;
    int nChk  = 0;
    int nFail = 0;

    // Reference model: at most one transaction in flight, described as a record.
    bit          mBusy;
    bit          mAccepted;
    bit          mStale;
    bit          mIsData;
    logic        mWr;
    logic [1:0]  mSize;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    bit          mInstDone;
    bit          mDataDone;
    logic [31:0] mInstRdata;
    logic [31:0] mDataRdata;

    // Random slave state.
    bit sPend;
    int sLat;

    task automatic chk1(input string name, input logic act, input logic exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s vec=%0d got=%b expected=%b", name, nVec, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, nVec, act, exp);
        end
    endtask

    task automatic modelReset();
        mBusy = 0; mAccepted = 0; mStale = 0; mIsData = 0;
        mWr = 1'b0; mSize = 2'd0; mAddr = Z; mWdata = Z;
        mInstDone = 0; mDataDone = 0; mInstRdata = Z; mDataRdata = Z;
    endtask

    task automatic modelStep(input vec_t v);
        bit setI;
        bit setD;
        bit fin;
        setI = 0;
        setD = 0;
        if (!mBusy) begin
            if (v.dReq && !mDataDone) begin
                mBusy = 1; mAccepted = 0; mStale = 0; mIsData = 1;
                mWr = v.dWr; mSize = v.dSize; mAddr = v.dAddr; mWdata = v.dWdata;
            end else if (v.iReq && !mInstDone) begin
                mBusy = 1; mAccepted = 0; mStale = 0; mIsData = 0;
                mWr = 1'b0; mSize = 2'd2; mAddr = v.iAddr;
            end
        end else begin
            fin = mAccepted ? v.dOk : (v.aOk && v.dOk);
            if (fin) begin
                if (!(mStale || v.fl)) begin
                    if (mIsData) begin
                        setD = 1;
                        if (!mWr) mDataRdata = v.rdata;
                    end else begin
                        setI = 1;
                        mInstRdata = v.rdata;
                    end
                end
                mBusy = 0;
            end else begin
                if (v.aOk) mAccepted = 1;
                if (v.fl) mStale = 1;
            end
        end
        if (!v.lst || v.fl) begin
            mInstDone = 0;
            mDataDone = 0;
        end
        if (setI) mInstDone = 1;
        if (setD) mDataDone = 1;
    endtask

    // Apply one vector at posedge+1, compare at posedge+2, advance the model.
    task automatic runCycle(input vec_t v, input bit useExp, input string tag);
        bit expReq;
        inst_req      = v.iReq;
        inst_addr     = v.iAddr;
        data_req      = v.dReq;
        data_wr       = v.dWr;
        data_size     = v.dSize;
        data_addr     = v.dAddr;
        data_wdata    = v.dWdata;
        bus_addr_ok   = v.aOk;
        bus_data_ok   = v.dOk;
        bus_rdata     = v.rdata;
        longest_stall = v.lst;
        flush_except  = v.fl;
        #1;
        nVec++;
        expReq = mBusy && !mAccepted;
        chk1({tag, " model i_stall"}, i_stall, v.iReq && !mInstDone);
        chk1({tag, " model d_stall"}, d_stall, v.dReq && !mDataDone);
        chk1({tag, " model bus_req"}, bus_req, expReq);
        if (expReq) begin
            chk1({tag, " model bus_wr"}, bus_wr, mWr);
            chk32({tag, " model bus_size"}, 32'(bus_size), 32'(mSize));
            chk32({tag, " model bus_addr"}, bus_addr, mAddr);
            if (mWr) chk32({tag, " model bus_wdata"}, bus_wdata, mWdata);
        end
        chk32({tag, " model inst_rdata"}, inst_rdata, mInstRdata);
        chk32({tag, " model data_rdata"}, data_rdata, mDataRdata);
        if (useExp) begin
            chk1({tag, " i_stall"}, i_stall, v.eI);
            chk1({tag, " d_stall"}, d_stall, v.eD);
            chk1({tag, " bus_req"}, bus_req, v.eReq);
            if (v.eReq) begin
                chk1({tag, " bus_wr"}, bus_wr, v.eWr);
                chk32({tag, " bus_size"}, 32'(bus_size), 32'(v.eSize));
                chk32({tag, " bus_addr"}, bus_addr, v.eAddr);
                if (v.eWr) chk32({tag, " bus_wdata"}, bus_wdata, v.eWdata);
            end
            chk32({tag, " inst_rdata"}, inst_rdata, v.eIR);
            chk32({tag, " data_rdata"}, data_rdata, v.eDR);
        end
        modelStep(v);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        // iReq iAddr dReq dWr dSize dAddr dWdata aOk dOk rdata lst fl | eI eD eReq eWr eSize eAddr eWdata eIR eDR
        // Fetch only: addr_ok in cycle 1, data_ok two cycles later.
        tbl.push_back(vec_t'{H,32'hBFC00000,L,L,2'd0,Z,Z,L,L,Z,H,L, H,L,L,L,2'd0,Z,Z,Z,Z});
        tbl.push_back(vec_t'{H,32'hBFC00000,L,L,2'd0,Z,Z,H,L,Z,H,L, H,L,H,L,2'd2,32'hBFC00000,Z,Z,Z});
        tbl.push_back(vec_t'{H,32'hBFC00000,L,L,2'd0,Z,Z,L,L,Z,H,L, H,L,L,L,2'd0,Z,Z,Z,Z});
        tbl.push_back(vec_t'{H,32'hBFC00000,L,L,2'd0,Z,Z,L,H,32'h24010001,H,L, H,L,L,L,2'd0,Z,Z,Z,Z});
        tbl.push_back(vec_t'{L,Z,L,L,2'd0,Z,Z,L,L,Z,L,L, L,L,L,L,2'd0,Z,Z,32'h24010001,Z});
        tbl.push_back(vec_t'{L,Z,L,L,2'd0,Z,Z,L,L,Z,L,L, L,L,L,L,2'd0,Z,Z,32'h24010001,Z});
        // Contention: data first, then fetch; d_stall drops before i_stall.
        tbl.push_back(vec_t'{H,32'hBFC00004,H,L,2'd2,32'h80000010,Z,L,L,Z,H,L, H,H,L,L,2'd0,Z,Z,32'h24010001,Z});
        tbl.push_back(vec_t'{H,32'hBFC00004,H,L,2'd2,32'h80000010,Z,H,H,32'h11112222,H,L, H,H,H,L,2'd2,32'h80000010,Z,32'h24010001,Z});
        tbl.push_back(vec_t'{H,32'hBFC00004,H,L,2'd2,32'h80000010,Z,L,L,Z,H,L, H,L,L,L,2'd0,Z,Z,32'h24010001,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00004,H,L,2'd2,32'h80000010,Z,H,H,32'h33334444,H,L, H,L,H,L,2'd2,32'hBFC00004,Z,32'h24010001,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00004,H,L,2'd2,32'h80000010,Z,L,L,Z,L,L, L,L,L,L,2'd0,Z,Z,32'h33334444,32'h11112222});
        tbl.push_back(vec_t'{L,Z,L,L,2'd0,Z,Z,L,L,Z,L,L, L,L,L,L,2'd0,Z,Z,32'h33334444,32'h11112222});
        // Hold: result kept while frozen, cleared on the first unfrozen cycle.
        tbl.push_back(vec_t'{H,32'hBFC00008,L,L,2'd0,Z,Z,L,L,Z,H,L, H,L,L,L,2'd0,Z,Z,32'h33334444,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00008,L,L,2'd0,Z,Z,H,H,32'h55556666,H,L, H,L,H,L,2'd2,32'hBFC00008,Z,32'h33334444,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00008,L,L,2'd0,Z,Z,L,L,Z,H,L, L,L,L,L,2'd0,Z,Z,32'h55556666,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00008,L,L,2'd0,Z,Z,L,L,Z,H,L, L,L,L,L,2'd0,Z,Z,32'h55556666,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00008,L,L,2'd0,Z,Z,L,L,Z,H,L, L,L,L,L,2'd0,Z,Z,32'h55556666,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00008,L,L,2'd0,Z,Z,L,L,Z,L,L, L,L,L,L,2'd0,Z,Z,32'h55556666,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC0000C,L,L,2'd0,Z,Z,L,L,Z,H,L, H,L,L,L,2'd0,Z,Z,32'h55556666,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC0000C,L,L,2'd0,Z,Z,H,H,32'h77778888,H,L, H,L,H,L,2'd2,32'hBFC0000C,Z,32'h55556666,32'h11112222});
        tbl.push_back(vec_t'{L,Z,L,L,2'd0,Z,Z,L,L,Z,L,L, L,L,L,L,2'd0,Z,Z,32'h77778888,32'h11112222});
        // Flush during WAIT: stale data dropped, next fetch issued from IDLE.
        tbl.push_back(vec_t'{H,32'hBFC00010,L,L,2'd0,Z,Z,L,L,Z,H,L, H,L,L,L,2'd0,Z,Z,32'h77778888,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00010,L,L,2'd0,Z,Z,H,L,Z,H,L, H,L,H,L,2'd2,32'hBFC00010,Z,32'h77778888,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00380,L,L,2'd0,Z,Z,L,L,Z,H,H, H,L,L,L,2'd0,Z,Z,32'h77778888,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00380,L,L,2'd0,Z,Z,L,H,32'hDEADBEEF,H,L, H,L,L,L,2'd0,Z,Z,32'h77778888,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00380,L,L,2'd0,Z,Z,L,L,Z,H,L, H,L,L,L,2'd0,Z,Z,32'h77778888,32'h11112222});
        tbl.push_back(vec_t'{H,32'hBFC00380,L,L,2'd0,Z,Z,H,H,32'h9999AAAA,H,L, H,L,H,L,2'd2,32'hBFC00380,Z,32'h77778888,32'h11112222});
        tbl.push_back(vec_t'{L,Z,L,L,2'd0,Z,Z,L,L,Z,L,L, L,L,L,L,2'd0,Z,Z,32'h9999AAAA,32'h11112222});
        // Byte store held through two cycles of addr_ok low.
        tbl.push_back(vec_t'{L,Z,H,H,2'd0,32'h80000003,32'h000000AA,L,L,Z,H,L, L,H,L,L,2'd0,Z,Z,32'h9999AAAA,32'h11112222});
        tbl.push_back(vec_t'{L,Z,H,H,2'd0,32'h80000003,32'h000000AA,L,L,Z,H,L, L,H,H,H,2'd0,32'h80000003,32'h000000AA,32'h9999AAAA,32'h11112222});
        tbl.push_back(vec_t'{L,Z,H,H,2'd0,32'h80000003,32'h00000055,L,L,Z,H,L, L,H,H,H,2'd0,32'h80000003,32'h000000AA,32'h9999AAAA,32'h11112222});
        tbl.push_back(vec_t'{L,Z,H,H,2'd0,32'h80000003,32'h00000055,H,L,Z,H,L, L,H,H,H,2'd0,32'h80000003,32'h000000AA,32'h9999AAAA,32'h11112222});
        tbl.push_back(vec_t'{L,Z,H,H,2'd0,32'h80000003,32'h00000055,L,H,32'h0000CAFE,H,L, L,H,L,L,2'd0,Z,Z,32'h9999AAAA,32'h11112222});
        tbl.push_back(vec_t'{L,Z,H,H,2'd0,32'h80000003,32'h00000055,L,L,Z,L,L, L,L,L,L,2'd0,Z,Z,32'h9999AAAA,32'h11112222});
        tbl.push_back(vec_t'{L,Z,L,L,2'd0,Z,Z,L,L,Z,L,L, L,L,L,L,2'd0,Z,Z,32'h9999AAAA,32'h11112222});

        // Reset state.
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = Z; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_addr = Z; data_wdata = Z; longest_stall = 1'b0; flush_except = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = Z;
        modelReset();
        sPend = 0;
        sLat = 0;
        @(posedge clk);
        #1;
        chk1("reset bus_req", bus_req, 1'b0);
        chk1("reset bus_wr", bus_wr, 1'b0);
        chk32("reset bus_size", 32'(bus_size), Z);
        chk32("reset bus_addr", bus_addr, Z);
        chk32("reset bus_wdata", bus_wdata, Z);
        chk32("reset inst_rdata", inst_rdata, Z);
        chk32("reset data_rdata", data_rdata, Z);
        rst = 1'b0;

        foreach (tbl[i]) runCycle(tbl[i], 1'b1, $sformatf("row%0d", i));

        // Reset asserted while a fetch waits for data.
        v = vec_t'{H,32'hBFC00020,L,L,2'd0,Z,Z,L,L,Z,H,L, L,L,L,L,2'd0,Z,Z,Z,Z};
        runCycle(v, 1'b0, "rstA");
        v.aOk = H;
        runCycle(v, 1'b0, "rstB");
        inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        #1;
        chk1("waitrst pre bus_req", bus_req, 1'b0);
        chk1("waitrst pre i_stall", i_stall, 1'b1);
        rst = 1'b1;
        #1;
        chk1("midrst bus_req", bus_req, 1'b0);
        chk1("midrst i_stall", i_stall, 1'b1);
        chk1("midrst d_stall", d_stall, 1'b1);
        chk32("midrst inst_rdata", inst_rdata, Z);
        chk32("midrst data_rdata", data_rdata, Z);
        modelReset();
        sPend = 0;
        @(posedge clk);
        #1;
        chk1("rsthold bus_req", bus_req, 1'b0);
        rst = 1'b0;

        // Random traffic against the model, with a randomly paced slave.
        for (int n = 0; n < 3000; n++) begin
            v.iReq   = ($urandom % 4) != 0;
            v.iAddr  = $urandom;
            v.dReq   = ($urandom % 2) != 0;
            v.dWr    = ($urandom % 2) != 0;
            v.dSize  = 2'($urandom % 3);
            v.dAddr  = $urandom;
            v.dWdata = $urandom;
            v.lst    = ($urandom % 2) != 0;
            v.fl     = ($urandom % 16) == 0;
            v.rdata  = $urandom;
            v.aOk    = 1'b0;
            v.dOk    = 1'b0;
            if (sPend) begin
                if (sLat == 0) v.dOk = 1'b1;
            end else if (bus_req && ($urandom % 3) == 0) begin
                v.aOk = 1'b1;
                if (($urandom % 4) == 0) v.dOk = 1'b1;
            end
            runCycle(v, 1'b0, "rand");
            if (sPend) begin
                if (v.dOk) sPend = 0;
                else sLat--;
            end else if (v.aOk && !v.dOk) begin
                sPend = 1;
                sLat = int'($urandom % 4);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-like bus (single outstanding transaction) between the instruction-fetch port (F stage) and the data-access port (M stage).
- Generates i_stall and d_stall for the hazard unit.
- Holds completed results until the pipeline advances (longest_stall low).
- Discards results of transactions that an exception flush has made stale.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- inst_req  in  1  F stage requests a fetch (level; held while stalled).
- inst_addr  in  ADDR_W  fetch address.
- inst_rdata  out  DATA_W  latched fetch data.
- i_stall  out  1  fetch not yet complete.
- data_req  in  1  M stage requests a load or store (level).
- data_wr  in  1  1 = store.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  DATA_W  latched load data.
- d_stall  out  1  data access not yet complete.
- longest_stall  in  1  pipeline frozen this cycle (from hazard unit).
- flush_except  in  1  exception flush (except_typeM != 0).
- bus_req  out  1  bus request.
- bus_wr  out  1  bus write.
- bus_size  out  2  bus size.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_addr_ok  in  1  slave accepted request this cycle.
- bus_data_ok  in  1  slave returns data / write ack this cycle.
- bus_rdata  in  DATA_W  bus read data.

Behaviour:
- Reset (async) values:
  - state = IDLE; owner = NONE.
  - bus_req, bus_wr, bus_size, bus_addr, bus_wdata = 0.
  - inst_done, data_done, discard = 0.
  - inst_rdata, data_rdata = 0.
  - A reset mid-transaction abandons the transaction. The slave shares rst.
- States:
  - IDLE:
    - If data_req & !data_done: latch data_wr/size/addr/wdata into the bus registers, owner = DATA, go to ADDR. Data has priority because it belongs to the older instruction.
    - Else if inst_req & !inst_done: latch inst_addr, bus_wr = 0, bus_size = 2, owner = INST, go to ADDR.
    - Else stay in IDLE.
  - ADDR:
    - bus_req = 1 with the registered fields. Fields stay stable until bus_addr_ok.
    - On bus_addr_ok go to WAIT and deassert bus_req on the following cycle.
    - If bus_addr_ok and bus_data_ok are both high in the same cycle, treat it as complete and go directly to IDLE.
  - WAIT:
    - bus_req = 0.
    - On bus_data_ok go to IDLE.
    - If !discard: owner INST sets inst_done and inst_rdata = bus_rdata; owner DATA sets data_done and data_rdata = bus_rdata (data_rdata is unchanged for stores).
- Minimum latency: request seen (cycle 0), IDLE→ADDR edge, addr_ok+data_ok in cycle 1, done set at edge of cycle 2. Stall is high for exactly 2 cycles.
- Stall outputs:
  - i_stall = inst_req & !inst_done.
  - d_stall = data_req & !data_done.
  - Both are combinational from registered state; no combinational bus→stall path.
- Done clear:
  - In any cycle with !longest_stall, the edge clears inst_done and data_done; the pipeline consumes the results then.
  - If the set condition and the clear condition occur in the same cycle, set wins.
- Flush:
  - If flush_except is high while state is ADDR or WAIT, set discard. The transaction still completes on the bus, but no done flag or rdata is written.
  - discard clears on return to IDLE.
  - flush_except also clears both done flags at the edge.
- Store-then-fetch: a store in flight blocks the fetch. The fetch starts in the IDLE cycle after completion, with no bubble beyond that IDLE cycle.
- Requests dropped while in ADDR are ignored. The latched transaction always completes.

Test Plan:
- Fetch only: inst_req = 1, addr 0xBFC00000; slave addr_ok in cycle 1, data_ok 2 cycles later with 0x24010001 → bus_addr = 0xBFC00000, size 2, i_stall high 4 cycles, inst_rdata = 0x24010001.
- Contention: inst_req and data_req (lw 0x80000010) rise together → data transaction issued first, then fetch; d_stall drops before i_stall; data_rdata and inst_rdata each correct.
- Hold: fetch completes while longest_stall = 1 for 3 more cycles → inst_done stays 1, i_stall 0, inst_rdata stable; cleared on first cycle with longest_stall = 0.
- Flush: flush_except pulses while a fetch is in WAIT; data_ok returns 0xDEADBEEF → inst_done stays 0, inst_rdata unchanged, next fetch issued from IDLE.
- Store: sb, addr 0x80000003, wdata 0x000000AA → bus_wr = 1, size 0, fields stable through 2 cycles of addr_ok low, d_stall clears after data_ok.
- Reset mid-WAIT: assert rst asynchronously → bus_req 0, state IDLE, stalls follow requests immediately, no done flags set.
